// File: rtl/core_seq_ctrl_pkg.sv
// Shared encodings and constants for the core_seq_ctrl sequencer.
package core_seq_ctrl_pkg;

  localparam int SEQ_STATE_WIDTH = 3;
  localparam int INST_WIDTH      = 32;

  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    SEQ_STATE_IDLE   = 3'd0,
    SEQ_STATE_FETCH  = 3'd1,
    SEQ_STATE_DECODE = 3'd2,
    SEQ_STATE_EXEC   = 3'd3,
    SEQ_STATE_MEM    = 3'd4,
    SEQ_STATE_WB     = 3'd5,
    SEQ_STATE_HALT   = 3'd6,
    SEQ_STATE_TRAP   = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    TRAP_CAUSE_NONE        = 2'd0,
    TRAP_CAUSE_ILLEGAL     = 2'd1,
    TRAP_CAUSE_IFU_TIMEOUT = 2'd2,
    TRAP_CAUSE_LSU_TIMEOUT = 2'd3
  } trap_cause_e;

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Instruction-fetch and load/store handshake bundle between the sequencer and memory side.
interface core_seq_ctrl_if;
  import core_seq_ctrl_pkg::*;

  logic                  ifu_req;
  logic                  ifu_rvalid;
  logic [INST_WIDTH-1:0] ifu_rdata;
  logic                  lsu_req;
  logic                  lsu_we;
  logic                  lsu_ack;

  modport master (
    output ifu_req, lsu_req, lsu_we,
    input  ifu_rvalid, ifu_rdata, lsu_ack
  );

  modport slave (
    input  ifu_req, lsu_req, lsu_we,
    output ifu_rvalid, ifu_rdata, lsu_ack
  );

endinterface

// File: rtl/core_seq_ctrl_wait_timer.sv
// Saturating wait counter; expire flags the last permitted wait cycle (limit 0 never expires).
module seq_wait_timer #(
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [WAIT_W-1:0] limit,
  output logic              expire
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != {WAIT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (limit != '0) && (cnt_q == (limit - 1'b1));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the NPC datapath.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  core_seq_ctrl_if.master            bus,
  output logic [INST_WIDTH-1:0]      inst_q,
  input  logic                       dec_mem,
  input  logic                       dec_store,
  input  logic                       dec_reg_wen,
  input  logic                       dec_ebreak,
  input  logic                       dec_unknown,
  output logic                       rf_we,
  output logic                       pc_we,
  output logic                       halted,
  output logic                       trap,
  output logic [1:0]                 trap_cause,
  output logic [SEQ_STATE_WIDTH-1:0] state_o,
  output logic [63:0]                cycle_cnt,
  output logic [63:0]                instret_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  seq_state_e            state_q, state_d;
  logic [INST_WIDTH-1:0] inst_d;
  trap_cause_e           trap_cause_q, trap_cause_d;
  logic                  wait_clear, wait_en, wait_expire;

  // The counter only runs while a response is outstanding; any other state rearms it.
  assign wait_clear = (state_q != SEQ_STATE_FETCH) && (state_q != SEQ_STATE_MEM);
  assign wait_en    = ((state_q == SEQ_STATE_FETCH) && !bus.ifu_rvalid) ||
                      ((state_q == SEQ_STATE_MEM)   && !bus.lsu_ack);

  seq_wait_timer #(.WAIT_W(WAIT_W)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wait_clear),
    .enable (wait_en),
    .limit  (WAIT_LIMIT),
    .expire (wait_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEQ_STATE_IDLE;
      inst_q       <= NOP_INST;
      trap_cause_q <= TRAP_CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      SEQ_STATE_IDLE:   state_d = SEQ_STATE_FETCH;
      SEQ_STATE_FETCH: begin
        if (bus.ifu_rvalid) begin
          inst_d  = bus.ifu_rdata;
          state_d = SEQ_STATE_DECODE;
        end else if (wait_expire) begin
          trap_cause_d = TRAP_CAUSE_IFU_TIMEOUT;
          state_d      = SEQ_STATE_TRAP;
        end
      end
      SEQ_STATE_DECODE: begin
        if (dec_unknown) begin
          trap_cause_d = TRAP_CAUSE_ILLEGAL;
          state_d      = SEQ_STATE_TRAP;
        end else if (dec_ebreak) begin
          state_d = SEQ_STATE_HALT;
        end else begin
          state_d = SEQ_STATE_EXEC;
        end
      end
      SEQ_STATE_EXEC:   state_d = dec_mem ? SEQ_STATE_MEM : SEQ_STATE_WB;
      SEQ_STATE_MEM: begin
        if (bus.lsu_ack) begin
          state_d = SEQ_STATE_WB;
        end else if (wait_expire) begin
          trap_cause_d = TRAP_CAUSE_LSU_TIMEOUT;
          state_d      = SEQ_STATE_TRAP;
        end
      end
      SEQ_STATE_WB:     state_d = SEQ_STATE_FETCH;
      SEQ_STATE_HALT:   state_d = SEQ_STATE_HALT;
      SEQ_STATE_TRAP:   state_d = SEQ_STATE_TRAP;
    endcase
  end

  // Stores carry reg_wen from the decoder, so WB masks it off for them.
  always_comb begin
    bus.ifu_req = 1'b0;
    bus.lsu_req = 1'b0;
    bus.lsu_we  = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    halted      = 1'b0;
    trap        = 1'b0;
    case (state_q)
      SEQ_STATE_FETCH: bus.ifu_req = 1'b1;
      SEQ_STATE_MEM: begin
        bus.lsu_req = 1'b1;
        bus.lsu_we  = dec_store;
      end
      SEQ_STATE_WB: begin
        pc_we = 1'b1;
        rf_we = dec_reg_wen & ~dec_store;
      end
      SEQ_STATE_HALT:  halted = 1'b1;
      SEQ_STATE_TRAP:  trap   = 1'b1;
      default: ;
    endcase
  end

  assign state_o    = state_q;
  assign trap_cause = trap_cause_q;

`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if ((state_q != SEQ_STATE_HALT) && (state_q != SEQ_STATE_TRAP)) begin
      cycle_cnt_d = cycle_cnt_q + 64'd1;
    end
    if (pc_we) begin
      instret_cnt_d = instret_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= 64'd0;
      instret_cnt_q <= 64'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: directed cycle tables plus randomized transaction streams.
module tb_core_seq_ctrl;

  localparam int MW = 4;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // dec bits: {unknown, ebreak, reg_wen, store, mem}; ex bits: {rf_we, pc_we, lsu_we}
  typedef struct {
    bit          rv;
    bit          ack;
    logic [31:0] rdata;
    logic [4:0]  dec;
    logic [2:0]  st;
    logic [2:0]  ex;
    logic [31:0] inst;
    logic [1:0]  cause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_mem, dec_store, dec_reg_wen, dec_ebreak, dec_unknown;
  logic [31:0] inst_q;
  logic        rf_we, pc_we, halted, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;
  logic [63:0] cycle_cnt, instret_cnt;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cur_idx = 0;
  longint unsigned cyc_m, ret_m;
  vec_t        vecs[$];
  logic [4:0]  g_dec;
  logic [31:0] g_inst;
  logic [1:0]  g_cause;

  core_seq_ctrl_if bus_if ();

  core_seq_ctrl #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .inst_q      (inst_q),
    .dec_mem     (dec_mem),
    .dec_store   (dec_store),
    .dec_reg_wen (dec_reg_wen),
    .dec_ebreak  (dec_ebreak),
    .dec_unknown (dec_unknown),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .halted      (halted),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .state_o     (state_o),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", name, cur_idx, act, exp);
    end
  endtask

  task automatic p(input bit rv, input bit ack, input logic [31:0] rd, input logic [4:0] dec,
                   input logic [2:0] st, input logic [2:0] ex, input logic [31:0] inst,
                   input logic [1:0] cause);
    vec_t v;
    v.rv = rv; v.ack = ack; v.rdata = rd; v.dec = dec;
    v.st = st; v.ex = ex; v.inst = inst; v.cause = cause;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus_if.ifu_rvalid = 1'b0; bus_if.ifu_rdata = '0; bus_if.lsu_ack = 1'b0;
    {dec_unknown, dec_ebreak, dec_reg_wen, dec_store, dec_mem} = 5'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc_m = 0;
    ret_m = 0;
  endtask

  task automatic checkOutput(input vec_t v);
    cmp("state_o",     64'(state_o),     64'(v.st));
    cmp("ifu_req",     64'(bus_if.ifu_req), 64'(v.st == 3'd1));
    cmp("lsu_req",     64'(bus_if.lsu_req), 64'(v.st == 3'd4));
    cmp("lsu_we",      64'(bus_if.lsu_we),  64'(v.ex[0]));
    cmp("rf_we",       64'(rf_we),       64'(v.ex[2]));
    cmp("pc_we",       64'(pc_we),       64'(v.ex[1]));
    cmp("halted",      64'(halted),      64'(v.st == 3'd6));
    cmp("trap",        64'(trap),        64'(v.st == 3'd7));
    cmp("trap_cause",  64'(trap_cause),  64'(v.cause));
    cmp("inst_q",      64'(inst_q),      64'(v.inst));
    cmp("cycle_cnt",   cycle_cnt,        PERF ? cyc_m : 64'd0);
    cmp("instret_cnt", instret_cnt,      PERF ? ret_m : 64'd0);
  endtask

  // Each vector covers one clock period: drive after the edge, sample at the falling edge.
  task automatic applyStimulus();
    foreach (vecs[i]) begin
      cur_idx = i;
      bus_if.ifu_rvalid = vecs[i].rv;
      bus_if.ifu_rdata  = vecs[i].rdata;
      bus_if.lsu_ack    = vecs[i].ack;
      {dec_unknown, dec_ebreak, dec_reg_wen, dec_store, dec_mem} = vecs[i].dec;
      @(negedge clk);
      checkOutput(vecs[i]);
      if (vecs[i].st != 3'd6 && vecs[i].st != 3'd7) cyc_m++;
      if (vecs[i].st == 3'd5) ret_m++;
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  task automatic pushc(input logic [2:0] st, input bit rv, input bit ack,
                       input logic [31:0] rd, input logic [2:0] ex);
    bit r, a;
    r = (st == 3'd1) ? rv  : bit'($urandom_range(0, 1));
    a = (st == 3'd4) ? ack : bit'($urandom_range(0, 1));
    p(r, a, rd, g_dec, st, ex, g_inst, g_cause);
  endtask

  // Reference model: expands random instruction-level transactions into per-cycle expectations.
  task automatic genSeq();
    int n, wf, wm, k;
    logic [2:0]  term;
    logic [31:0] rd;
    g_dec = 5'b0; g_inst = 32'h0000_0013; g_cause = 2'd0; term = 3'd0;
    pushc(3'd0, 1'b0, 1'b0, $urandom, 3'b000);
    n = $urandom_range(1, 6);
    for (int t = 0; t < n && term == 3'd0; t++) begin
      wf = $urandom_range(0, 5);
      k  = $urandom_range(0, 15);
      rd = $urandom;
      for (int w = 0; w < wf && w < MW; w++) pushc(3'd1, 1'b0, 1'b0, $urandom, 3'b000);
      if (wf >= MW) begin
        g_cause = 2'd2;
        term = 3'd7;
      end else begin
        if (k == 0)      g_dec = {1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
        else if (k == 1) g_dec = 5'b01000;
        else if (k <= 5) g_dec = 5'b00101;
        else if (k <= 8) g_dec = 5'b00111;
        else             g_dec = {2'b00, 1'($urandom_range(0, 1)), 2'b00};
        pushc(3'd1, 1'b1, 1'b0, rd, 3'b000);
        g_inst = rd;
        pushc(3'd2, 1'b0, 1'b0, $urandom, 3'b000);
        if (g_dec[4]) begin
          g_cause = 2'd1;
          term = 3'd7;
        end else if (g_dec[3]) begin
          term = 3'd6;
        end else begin
          pushc(3'd3, 1'b0, 1'b0, $urandom, 3'b000);
          if (g_dec[0]) begin
            wm = $urandom_range(0, 5);
            for (int w = 0; w < wm && w < MW; w++)
              pushc(3'd4, 1'b0, 1'b0, $urandom, {2'b00, g_dec[1]});
            if (wm >= MW) begin
              g_cause = 2'd3;
              term = 3'd7;
            end else begin
              pushc(3'd4, 1'b0, 1'b1, $urandom, {2'b00, g_dec[1]});
            end
          end
          if (term == 3'd0) pushc(3'd5, 1'b0, 1'b0, $urandom, {g_dec[2] & ~g_dec[1], 1'b1, 1'b0});
        end
      end
    end
    if (term != 3'd0) repeat (3) pushc(term, 1'b0, 1'b0, $urandom, 3'b000);
    else pushc(3'd1, 1'b0, 1'b0, $urandom, 3'b000);
  endtask

  initial begin
    // addi, lw with 3-cycle ack, sd; stray valid/ack outside FETCH/MEM must be ignored
    doReset();
    p(0,0,32'h0,        5'h00, 3'd0, 3'b000, 32'h00000013, 2'd0);
    p(1,0,32'h00500093, 5'h04, 3'd1, 3'b000, 32'h00000013, 2'd0);
    p(1,0,32'h0,        5'h04, 3'd2, 3'b000, 32'h00500093, 2'd0);
    p(0,1,32'h0,        5'h04, 3'd3, 3'b000, 32'h00500093, 2'd0);
    p(0,0,32'h0,        5'h04, 3'd5, 3'b110, 32'h00500093, 2'd0);
    p(1,0,32'h0002a103, 5'h05, 3'd1, 3'b000, 32'h00500093, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd2, 3'b000, 32'h0002a103, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd3, 3'b000, 32'h0002a103, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd4, 3'b000, 32'h0002a103, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd4, 3'b000, 32'h0002a103, 2'd0);
    p(0,1,32'h0,        5'h05, 3'd4, 3'b000, 32'h0002a103, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd5, 3'b110, 32'h0002a103, 2'd0);
    p(1,0,32'h00113423, 5'h07, 3'd1, 3'b000, 32'h0002a103, 2'd0);
    p(0,0,32'h0,        5'h07, 3'd2, 3'b000, 32'h00113423, 2'd0);
    p(0,0,32'h0,        5'h07, 3'd3, 3'b000, 32'h00113423, 2'd0);
    p(0,1,32'h0,        5'h07, 3'd4, 3'b001, 32'h00113423, 2'd0);
    p(0,0,32'h0,        5'h07, 3'd5, 3'b010, 32'h00113423, 2'd0);
    p(0,0,32'h0,        5'h07, 3'd1, 3'b000, 32'h00113423, 2'd0);
    applyStimulus();

    // ebreak halts; later fetch data is ignored
    doReset();
    p(0,0,32'h0,        5'h00, 3'd0, 3'b000, 32'h00000013, 2'd0);
    p(1,0,32'h00100073, 5'h08, 3'd1, 3'b000, 32'h00000013, 2'd0);
    p(0,0,32'h0,        5'h08, 3'd2, 3'b000, 32'h00100073, 2'd0);
    p(1,1,32'hffffffff, 5'h00, 3'd6, 3'b000, 32'h00100073, 2'd0);
    p(1,1,32'hffffffff, 5'h00, 3'd6, 3'b000, 32'h00100073, 2'd0);
    applyStimulus();

    // unknown wins over ebreak
    doReset();
    p(0,0,32'h0,        5'h00, 3'd0, 3'b000, 32'h00000013, 2'd0);
    p(1,0,32'hffffffff, 5'h18, 3'd1, 3'b000, 32'h00000013, 2'd0);
    p(0,0,32'h0,        5'h18, 3'd2, 3'b000, 32'hffffffff, 2'd0);
    p(1,1,32'h0,        5'h18, 3'd7, 3'b000, 32'hffffffff, 2'd1);
    p(0,0,32'h0,        5'h18, 3'd7, 3'b000, 32'hffffffff, 2'd1);
    applyStimulus();

    // fetch timeout after exactly MW cycles
    doReset();
    p(0,0,32'h0, 5'h00, 3'd0, 3'b000, 32'h00000013, 2'd0);
    for (int i = 0; i < MW; i++) p(0,0,32'h0, 5'h00, 3'd1, 3'b000, 32'h00000013, 2'd0);
    p(1,0,32'h1234, 5'h00, 3'd7, 3'b000, 32'h00000013, 2'd2);
    p(0,0,32'h0,    5'h00, 3'd7, 3'b000, 32'h00000013, 2'd2);
    applyStimulus();

    // response on the limit cycle beats the timeout
    doReset();
    p(0,0,32'h0, 5'h00, 3'd0, 3'b000, 32'h00000013, 2'd0);
    for (int i = 0; i < MW - 1; i++) p(0,0,32'h0, 5'h00, 3'd1, 3'b000, 32'h00000013, 2'd0);
    p(1,0,32'h00500093, 5'h04, 3'd1, 3'b000, 32'h00000013, 2'd0);
    p(0,0,32'h0,        5'h04, 3'd2, 3'b000, 32'h00500093, 2'd0);
    p(0,0,32'h0,        5'h04, 3'd3, 3'b000, 32'h00500093, 2'd0);
    p(0,0,32'h0,        5'h04, 3'd5, 3'b110, 32'h00500093, 2'd0);
    p(0,0,32'h0,        5'h04, 3'd1, 3'b000, 32'h00500093, 2'd0);
    applyStimulus();

    // memory timeout
    doReset();
    p(0,0,32'h0,        5'h00, 3'd0, 3'b000, 32'h00000013, 2'd0);
    p(1,0,32'h0002a103, 5'h05, 3'd1, 3'b000, 32'h00000013, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd2, 3'b000, 32'h0002a103, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd3, 3'b000, 32'h0002a103, 2'd0);
    for (int i = 0; i < MW; i++) p(0,0,32'h0, 5'h05, 3'd4, 3'b000, 32'h0002a103, 2'd0);
    p(0,1,32'h0,        5'h05, 3'd7, 3'b000, 32'h0002a103, 2'd3);
    applyStimulus();

    // asynchronous reset in the middle of MEM
    doReset();
    p(0,0,32'h0,        5'h00, 3'd0, 3'b000, 32'h00000013, 2'd0);
    p(1,0,32'h0002a103, 5'h05, 3'd1, 3'b000, 32'h00000013, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd2, 3'b000, 32'h0002a103, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd3, 3'b000, 32'h0002a103, 2'd0);
    p(0,0,32'h0,        5'h05, 3'd4, 3'b000, 32'h0002a103, 2'd0);
    applyStimulus();
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_lsu_req", 64'(bus_if.lsu_req), 64'd0);
    cmp("async_rst_state",   64'(state_o),        64'd0);
    cmp("async_rst_inst",    64'(inst_q),         64'h13);
    cmp("async_rst_pc_we",   64'(pc_we),          64'd0);
    doReset();
    p(0,0,32'h0, 5'h00, 3'd0, 3'b000, 32'h00000013, 2'd0);
    p(0,0,32'h0, 5'h00, 3'd1, 3'b000, 32'h00000013, 2'd0);
    applyStimulus();

    repeat (40) begin
      doReset();
      genSeq();
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC datapath. It fetches an instruction over a request/valid handshake, latches it, and feeds it to the `ctrl` decoder. It then steps the decoded instruction through EXEC, an optional memory access, and writeback. It qualifies the decoder's register write and PC update into single-cycle strobes, halts on `ebreak`, and traps on illegal instructions or bus timeouts.

Parameters:
- MAX_WAIT, 255: maximum cycles to wait for an `ifu_rvalid` / `lsu_ack` response. 0 disables the timeout.
- WAIT_W, 8: width of the wait counter. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- ifu_req  out  1  instruction fetch request, high throughout FETCH
- ifu_rvalid  in  1  fetch data valid; sampled only in FETCH
- ifu_rdata  in  32  fetched instruction
- inst_q  out  32  latched instruction, drives decoder `inst`
- dec_mem  in  1  decoder `s_flag` (load/store)
- dec_store  in  1  store indicator (opcode 0100011)
- dec_reg_wen  in  1  decoder `reg_wen`
- dec_ebreak  in  1  decoder `ebreak_flag`
- dec_unknown  in  1  |`unknown_code`
- lsu_req  out  1  memory request, high throughout MEM
- lsu_we  out  1  write qualifier, equals dec_store while in MEM, else 0
- lsu_ack  in  1  memory done; sampled only in MEM
- rf_we  out  1  register file write strobe, one cycle
- pc_we  out  1  PC update strobe, one cycle
- halted  out  1  sticky; set on ebreak
- trap  out  1  sticky; set on illegal instruction or timeout
- trap_cause  out  2  0 none, 1 illegal, 2 IFU timeout, 3 LSU timeout
- state_o  out  3  current state encoding
- cycle_cnt  out  64  see Optional Feature
- instret_cnt  out  64  see Optional Feature

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE, inst_q = 32'h0000_0013 (nop), trap_cause = 0.
  - All strobes, requests, halted and trap are 0; counters are 0.
  - Asserting reset mid-operation aborts immediately; no strobe is emitted.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7. All outputs are Moore (registered state only).
- IDLE: after one cycle, go to FETCH.
- FETCH:
  - ifu_req=1.
  - On ifu_rvalid: inst_q <= ifu_rdata; go to DECODE.
- DECODE: priority dec_unknown > dec_ebreak.
  - dec_unknown: go to TRAP with cause 1.
  - dec_ebreak: go to HALT.
  - Otherwise: go to EXEC.
- EXEC: go to MEM if dec_mem, else WB. This cycle is reserved for ALU settle.
- MEM:
  - lsu_req=1, lsu_we=dec_store.
  - On lsu_ack: go to WB.
- WB:
  - pc_we=1.
  - rf_we = dec_reg_wen & ~dec_store. The decoder asserts `reg_wen` for stores; this gating suppresses it.
  - Go to FETCH.
- HALT and TRAP are absorbing; only reset exits them. halted=1 in HALT; trap=1 in TRAP.
- Latency at zero wait (response in first FETCH/MEM cycle):
  - Non-memory instruction: 4 cycles, FETCH to WB.
  - Load/store: 5 cycles.
- inst_q changes only on FETCH acceptance. Decoder inputs are therefore stable from DECODE through WB.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle without a response; saturates.
  - If MAX_WAIT≠0 and counter == MAX_WAIT-1 with no response that cycle: go to TRAP with cause 2 (FETCH) or 3 (MEM).
  - A response on the limit cycle wins over timeout.
- ifu_rvalid outside FETCH and lsu_ack outside MEM are ignored.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle except in HALT/TRAP.
  - instret_cnt increments on each pc_we.
  - Both wrap modulo 2^64.
- Undefined: both ports are present and tied to 64'd0; no counter flops.

Decomposition:
- Shared defines/package:
  - SEQ_STATE_* encodings and SEQ_STATE_WIDTH=3
  - TRAP_CAUSE_* codes
  - NOP_INST constant
  - INST_WIDTH=32
- Sub-module seq_wait_timer (clear, enable, limit in; expire out) holds the wait counter.

Test Plan:
- Zero-wait addi `00500093` with dec_reg_wen=1 → states 1,2,3,5; rf_we=1 and pc_we=1 in the 4th cycle after FETCH entry; instret_cnt=1.
- Load `lw`, dec_mem=1, lsu_ack after 3 cycles → lsu_req high 3 cycles, lsu_we=0, then WB with rf_we=1.
- Store `sd`, dec_mem=1, dec_store=1, dec_reg_wen=1 → lsu_we=1 during MEM; in WB rf_we=0 and pc_we=1.
- Fetch of `00100073` with dec_ebreak=1 → HALT (state_o=6), halted=1, no pc_we; further ifu_rvalid ignored.
- dec_unknown=1 → TRAP with trap_cause=1. With MAX_WAIT=4 and no ifu_rvalid → TRAP with cause 2 after exactly 4 FETCH cycles. ifu_rvalid on the 4th cycle → DECODE instead.
- Assert rst_n=0 during MEM → lsu_req falls without a clock edge; after release, IDLE then FETCH, inst_q=00000013.
